// File: rtl/data_ram_pkg.sv
// Shared types and constants for the two-requester data RAM arbiter.
// The RAM holds 2**RAM_IDX_W words; any word address with bits above RAM_IDX_W set is out of range.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_R0 = 1'b0;
    localparam owner_t OWN_R1 = 1'b1;

    localparam int RAM_IDX_W = 12;
    localparam int ADDR_W    = 30;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1:RAM_IDX_W] == '0);
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr.sv
// Two-way requester pick: fixed priority to r0, or alternate against the last winner.
module rr_arbiter2
    import data_ram_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (fixed_prio || (last == OWN_R1)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one registered-output RAM port between two requesters: grant, issue, respond.
// One access every two cycles at peak; out-of-range accesses complete with err and no write.
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic [BE_W-1:0]   r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic [BE_W-1:0]   r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic [BE_W-1:0]   ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q,  last_d;
    logic [BE_W-1:0]     we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [1:0]          arb_grant;
    logic [1:0]          gnt_vec;
    logic                can_grant;
    logic                in_range;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({r1_req, r0_req}),
        .last       (last_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (arb_grant)
    );

    // Grants only from IDLE or RESP; rst masks the combinational grant so reset is immediate.
    assign can_grant = ((state_q == IDLE) || (state_q == RESP)) && !rst;
    assign gnt_vec   = can_grant ? arb_grant : 2'b00;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE:    state_d = (gnt_vec != 2'b00) ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = (gnt_vec != 2'b00) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        if (gnt_vec[1]) begin
            owner_d = OWN_R1;
            last_d  = OWN_R1;
            we_d    = r1_we;
            addr_d  = r1_addr;
            wdata_d = r1_wdata;
        end else if (gnt_vec[0]) begin
            owner_d = OWN_R0;
            last_d  = OWN_R0;
            we_d    = r0_we;
            addr_d  = r0_addr;
            wdata_d = r0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_R0;
            last_q  <= OWN_R1;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The captured address stays put through RESP, so range status is valid there too.
    assign in_range   = addr_in_range(addr_q);

    assign ram_we     = ((state_q == ISSUE) && in_range) ? we_q : '0;
    assign ram_addr   = addr_q;
    assign ram_din    = wdata_q;

    assign resp_valid = (state_q == RESP);
    assign resp_data  = in_range ? ram_dout : '0;

    assign r0_gnt     = gnt_vec[0];
    assign r1_gnt     = gnt_vec[1];

    assign r0_rvalid  = resp_valid && (owner_q == OWN_R0);
    assign r1_rvalid  = resp_valid && (owner_q == OWN_R1);

    assign r0_rdata   = r0_rvalid ? resp_data : '0;
    assign r1_rdata   = r1_rvalid ? resp_data : '0;

    assign r0_err     = r0_rvalid && !in_range;
    assign r1_err     = r1_rvalid && !in_range;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters on shared stimulus, each with its own RAM.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;

    logic        r0_req, r1_req;
    logic [3:0]  r0_we, r1_we;
    logic [29:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;

    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    logic        d1_r0_gnt, d1_r0_rvalid, d1_r0_err, d1_r1_gnt, d1_r1_rvalid, d1_r1_err;
    logic [31:0] d1_r0_rdata, d1_r1_rdata;
    logic [3:0]  d1_ram_we;
    logic [29:0] d1_ram_addr;
    logic [31:0] d1_ram_din, d1_ram_dout;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem1 [0:4095];

    int total = 0;
    int bad   = 0;

    data_ram_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    data_ram_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(d1_r0_gnt), .r0_rvalid(d1_r0_rvalid), .r0_rdata(d1_r0_rdata), .r0_err(d1_r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(d1_r1_gnt), .r1_rvalid(d1_r1_rvalid), .r1_rdata(d1_r1_rdata), .r1_err(d1_r1_err),
        .ram_we(d1_ram_we), .ram_addr(d1_ram_addr), .ram_din(d1_ram_din), .ram_dout(d1_ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered read-first RAMs with byte enables; preloaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem0[3] <= 32'h1122_3344;
            mem0[5] <= 32'h0053_0333;
            ram_dout <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem0[ram_addr[11:0]][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= mem0[ram_addr[11:0]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mem1[3] <= 32'h1122_3344;
            mem1[5] <= 32'h0053_0333;
            d1_ram_dout <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (d1_ram_we[b]) mem1[d1_ram_addr[11:0]][8*b +: 8] <= d1_ram_din[8*b +: 8];
            d1_ram_dout <= mem1[d1_ram_addr[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        r0_req = 1'b0; r0_we = 4'h0; r0_addr = 30'h0; r0_wdata = 32'h0;
        r1_req = 1'b0; r1_we = 4'h0; r1_addr = 30'h0; r1_wdata = 32'h0;

        // Reset: grants masked even with a request pending
        repeat (2) @(posedge clk);
        #1;
        r0_req = 1'b1; r0_addr = 30'd5; r0_we = 4'h0;
        mid();
        chk("rst_r0_gnt", {31'h0, r0_gnt}, 32'h0);
        chk("rst_r1_gnt", {31'h0, r1_gnt}, 32'h0);
        chk("rst_rvalid", {30'h0, r0_rvalid, r1_rvalid}, 32'h0);
        chk("rst_err", {30'h0, r0_err, r1_err}, 32'h0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst_ram_addr", {2'b0, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        chk("rst_r0_rdata", r0_rdata, 32'h0);

        // Single read of word 5 by r0
        tick(); rst = 1'b0;
        mid();
        chk("rd_gnt_t", {30'h0, r1_gnt, r0_gnt}, 32'h1);
        tick(); r0_req = 1'b0;
        mid();
        chk("rd_we_t1", {28'h0, ram_we}, 32'h0);
        chk("rd_addr_t1", {2'b0, ram_addr}, 32'd5);
        chk("rd_nognt_t1", {30'h0, r1_gnt, r0_gnt}, 32'h0);
        tick(); mid();
        chk("rd_rvalid_t2", {30'h0, r1_rvalid, r0_rvalid}, 32'h1);
        chk("rd_rdata_t2", r0_rdata, 32'h0053_0333);
        chk("rd_err_t2", {31'h0, r0_err}, 32'h0);
        tick(); mid();
        chk("rd_idle_rvalid", {31'h0, r0_rvalid}, 32'h0);

        // Byte write by r1 to word 3, byte 1
        tick(); r1_req = 1'b1; r1_we = 4'b0010; r1_addr = 30'd3; r1_wdata = 32'h0000_AB00;
        mid();
        chk("wr_gnt_t", {30'h0, r1_gnt, r0_gnt}, 32'h2);
        tick(); r1_req = 1'b0;
        mid();
        chk("wr_we_t1", {28'h0, ram_we}, 32'h2);
        chk("wr_addr_t1", {2'b0, ram_addr}, 32'd3);
        chk("wr_din_t1", ram_din, 32'h0000_AB00);
        tick(); mid();
        chk("wr_rvalid_t2", {30'h0, r1_rvalid, r0_rvalid}, 32'h2);
        chk("wr_err_t2", {31'h0, r1_err}, 32'h0);
        chk("wr_we_cleared_t2", {28'h0, ram_we}, 32'h0);

        // Read back word 3: only byte 1 changed
        tick(); r1_req = 1'b1; r1_we = 4'h0; r1_addr = 30'd3;
        mid();
        chk("rb_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h2);
        tick(); r1_req = 1'b0;
        mid();
        tick(); mid();
        chk("rb_rvalid", {31'h0, r1_rvalid}, 32'h1);
        chk("rb_rdata", r1_rdata, 32'h1122_AB44);

        // Continuous contention: r0 reads word 5, r1 reads word 3
        tick();
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 30'd5;
        r1_req = 1'b1; r1_we = 4'h0; r1_addr = 30'd3;
        mid();
        chk("ct0_rr_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h1);
        chk("ct0_fp_gnt", {30'h0, d1_r1_gnt, d1_r0_gnt}, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(); mid();
            if (k % 2 == 1) begin
                chk($sformatf("ct%0d_rr_nognt", k), {30'h0, r1_gnt, r0_gnt}, 32'h0);
                chk($sformatf("ct%0d_fp_nognt", k), {30'h0, d1_r1_gnt, d1_r0_gnt}, 32'h0);
            end else begin
                chk($sformatf("ct%0d_rr_gnt", k), {30'h0, r1_gnt, r0_gnt},
                    (k % 4 == 2) ? 32'h2 : 32'h1);
                chk($sformatf("ct%0d_fp_gnt", k), {30'h0, d1_r1_gnt, d1_r0_gnt}, 32'h1);
                chk($sformatf("ct%0d_rr_rvalid", k), {30'h0, r1_rvalid, r0_rvalid},
                    (k % 4 == 2) ? 32'h1 : 32'h2);
                chk($sformatf("ct%0d_rr_rdata", k), (k % 4 == 2) ? r0_rdata : r1_rdata,
                    (k % 4 == 2) ? 32'h0053_0333 : 32'h1122_AB44);
                chk($sformatf("ct%0d_fp_r0", k), {d1_r0_rdata[30:0], d1_r0_rvalid},
                    {31'h0053_0333, 1'b1});
                chk($sformatf("ct%0d_fp_quiet", k),
                    {28'h0, d1_r1_rvalid, d1_r1_err, d1_r0_err, r0_err}, 32'h0);
            end
        end
        tick(); r0_req = 1'b0; r1_req = 1'b0;
        mid();
        tick(); mid();
        chk("ct8_rr_nognt", {30'h0, r1_gnt, r0_gnt}, 32'h0);
        chk("ct8_rr_rvalid", {30'h0, r1_rvalid, r0_rvalid}, 32'h2);
        tick(); mid();
        chk("ct9_idle", {30'h0, r1_rvalid, r0_rvalid}, 32'h0);

        // Out-of-range write by r0: byte address bit 14 set
        tick(); r0_req = 1'b1; r0_we = 4'hF; r0_addr = 30'h0000_1000; r0_wdata = 32'hDEAD_BEEF;
        mid();
        chk("oor_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h1);
        tick(); r0_req = 1'b0;
        mid();
        chk("oor_we", {28'h0, ram_we}, 32'h0);
        chk("oor_addr", {2'b0, ram_addr}, 32'h0000_1000);
        tick(); mid();
        chk("oor_rvalid", {30'h0, r1_rvalid, r0_rvalid}, 32'h1);
        chk("oor_err", {30'h0, r1_err, r0_err}, 32'h1);
        chk("oor_rdata", r0_rdata, 32'h0);

        // Reset asserted during ISSUE of an r0 write
        tick(); r0_req = 1'b1; r0_we = 4'hF; r0_addr = 30'd7; r0_wdata = 32'h1234_5678;
        mid();
        chk("ri_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h1);
        tick(); r0_req = 1'b0;
        mid();
        chk("ri_issue_we", {28'h0, ram_we}, 32'hF);
        #1;
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 30'd5;
        r1_req = 1'b1; r1_we = 4'h0; r1_addr = 30'd3;
        #1;
        chk("ri_we", {28'h0, ram_we}, 32'h0);
        chk("ri_addr", {2'b0, ram_addr}, 32'h0);
        chk("ri_din", ram_din, 32'h0);
        chk("ri_gnt_masked", {30'h0, r1_gnt, r0_gnt}, 32'h0);
        tick(); mid();
        chk("ri_no_rvalid", {28'h0, r1_rvalid, r0_rvalid, r1_err, r0_err}, 32'h0);
        chk("ri_rdata", r0_rdata, 32'h0);
        tick(); rst = 1'b0;
        mid();
        chk("ri_next_rr_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h1);
        chk("ri_next_fp_gnt", {30'h0, d1_r1_gnt, d1_r0_gnt}, 32'h1);
        tick(); r0_req = 1'b0; r1_req = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
